// File: rtl/svnet_pipe.sv
// Elastic valid/ready pipeline of DEPTH stages; optional skid stages; optional occupancy port (SVNET_PIPE_COUNT_EN).
// Latency: DEPTH cycles from input transfer to out_valid when unstalled; DEPTH=0 is a combinational pass-through.
// Backpressure: REG_READY=1 gives a registered in_ready per stage; REG_READY=0 gives a combinational ready chain.
module svnet_pipe #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 1,
    parameter int REG_READY = 1,
    localparam int CAP      = (DEPTH == 0) ? 0 : ((REG_READY != 0) ? 2 * DEPTH : DEPTH),
    localparam int CNT_W    = (CAP == 0) ? 1 : $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SVNET_PIPE_COUNT_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    if (DEPTH == 0) begin : g_bypass
        logic bypass_unused;
        assign bypass_unused = ^{clk, rst, flush};
        assign out_data  = in_data;
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
`ifdef SVNET_PIPE_COUNT_EN
        assign count = '0;
`endif
    end else begin : g_pipe
        // Index i is the boundary feeding stage i; index DEPTH is the block output.
        logic [DEPTH:0][WIDTH-1:0] st_data;
        logic [DEPTH:0]            st_valid;
        logic [DEPTH:0]            st_ready;

        assign st_data[0]      = in_data;
        assign st_valid[0]     = in_valid;
        assign st_ready[DEPTH] = out_ready;
        assign out_data        = st_data[DEPTH];
        assign out_valid       = st_valid[DEPTH];
        // Stage registers are overwritten by rst/flush, so only the advertised ready needs gating.
        assign in_ready        = st_ready[0] & ~rst & ~flush;

        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            if (REG_READY != 0) begin : g_skid
                logic [WIDTH-1:0] main_data;
                logic [WIDTH-1:0] skid_data;
                logic             main_valid;
                logic             skid_valid;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        main_valid <= 1'b0;
                        skid_valid <= 1'b0;
                        main_data  <= '0;
                        skid_data  <= '0;
                    end else if (flush) begin
                        main_valid <= 1'b0;
                        skid_valid <= 1'b0;
                    end else if (!main_valid || st_ready[i+1]) begin
                        if (skid_valid) begin
                            main_valid <= 1'b1;
                            main_data  <= skid_data;
                            skid_valid <= 1'b0;
                        end else begin
                            main_valid <= st_valid[i];
                            if (st_valid[i]) begin
                                main_data <= st_data[i];
                            end
                        end
                    end else if (st_valid[i] && !skid_valid) begin
                        // Main is stalled: park the beat we already promised to take.
                        skid_valid <= 1'b1;
                        skid_data  <= st_data[i];
                    end
                end

                assign st_ready[i]   = ~skid_valid;
                assign st_valid[i+1] = main_valid;
                assign st_data[i+1]  = main_data;
            end else begin : g_single
                logic [WIDTH-1:0] data_q;
                logic             valid_q;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        valid_q <= 1'b0;
                        data_q  <= '0;
                    end else if (flush) begin
                        valid_q <= 1'b0;
                    end else if (!valid_q || st_ready[i+1]) begin
                        valid_q <= st_valid[i];
                        if (st_valid[i]) begin
                            data_q <= st_data[i];
                        end
                    end
                end

                assign st_ready[i]   = ~valid_q | st_ready[i+1];
                assign st_valid[i+1] = valid_q;
                assign st_data[i+1]  = data_q;
            end
        end

`ifdef SVNET_PIPE_COUNT_EN
        logic in_fire;
        logic out_fire;
        assign in_fire  = in_valid & in_ready;
        assign out_fire = out_valid & out_ready;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                count <= '0;
            end else if (in_fire && !out_fire) begin
                count <= count + CNT_W'(1);
            end else if (!in_fire && out_fire) begin
                count <= count - CNT_W'(1);
            end
        end
`endif
    end

endmodule

// File: tb/tb_svnet_pipe.sv
// Bench for svnet_pipe: DEPTH=3 skid pipe, DEPTH=2 combinational-ready pipe under random traffic, DEPTH=0 pass-through.
// Queue scoreboards track accepted beats; the pass-through is checked from a vector table.
module tb_svnet_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // DUT A: DEPTH=3, REG_READY=1
    logic       a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    // DUT B: DEPTH=2, REG_READY=0
    logic       b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data;
    // DUT C: DEPTH=0
    logic       c_rst, c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [7:0] c_in_data, c_out_data;
`ifdef SVNET_PIPE_COUNT_EN
    logic [2:0] a_count;
    logic [1:0] b_count;
    logic [0:0] c_count;
`endif

    svnet_pipe #(.WIDTH(8), .DEPTH(3), .REG_READY(1)) u_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready)
`ifdef SVNET_PIPE_COUNT_EN
        , .count(a_count)
`endif
    );

    svnet_pipe #(.WIDTH(8), .DEPTH(2), .REG_READY(0)) u_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef SVNET_PIPE_COUNT_EN
        , .count(b_count)
`endif
    );

    svnet_pipe #(.WIDTH(8), .DEPTH(0), .REG_READY(1)) u_c (
        .clk(clk), .rst(c_rst), .flush(c_flush),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready)
`ifdef SVNET_PIPE_COUNT_EN
        , .count(c_count)
`endif
    );

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit a_armed = 1'b0;
    bit b_armed = 1'b0;

    // Scoreboard A: sampled mid-cycle, occupancy check first, then this cycle's transfers.
    always @(negedge clk) begin
        if (a_rst) begin
            qa.delete();
            check("a_rdy_in_rst", a_in_ready, 0);
        end else begin
`ifdef SVNET_PIPE_COUNT_EN
            if (a_armed) check("a_count", a_count, qa.size());
`endif
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL a_extra_beat: got 0x%0h, expected no beat at %0t", a_out_data, $time);
                end else begin
                    check("a_order", a_out_data, qa.pop_front());
                end
            end
            if (a_flush) begin
                check("a_rdy_in_flush", a_in_ready, 0);
                qa.delete();
            end else if (a_in_valid && a_in_ready) begin
                qa.push_back(a_in_data);
            end
        end
    end

    // Scoreboard B: with two single-entry stages, only a full pipe can stall the input.
    always @(negedge clk) begin
        if (b_rst) begin
            qb.delete();
        end else begin
            if (b_armed) begin
                check("b_in_ready", b_in_ready, (qb.size() != 2) || b_out_ready);
`ifdef SVNET_PIPE_COUNT_EN
                check("b_count", b_count, qb.size());
`endif
            end
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_extra_beat: got 0x%0h, expected no beat at %0t", b_out_data, $time);
                end else begin
                    check("b_order", b_out_data, qb.pop_front());
                end
            end
            if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       rst;
        logic       flush;
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ready;
    } vec_t;

    initial begin
        vec_t tv[8];
        int   nxt;
        int   acc;
        int   sent;
        int   cyc;
        bit   b_acc;

        tv[0] = '{1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1};
        tv[1] = '{1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 8'h33, 1'b0};
        tv[2] = '{1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1};
        tv[3] = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0};
        tv[4] = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1};
        tv[5] = '{1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 8'h80, 1'b0};
        tv[6] = '{1'b1, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1};
        tv[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};

        a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        c_rst = 1'b0; c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        a_armed = 1'b1;
        b_armed = 1'b1;
        #1;
        check("a_rdy_after_rst", a_in_ready, 1);
        check("a_vld_after_rst", a_out_valid, 0);
        check("a_dat_after_rst", a_out_data, 0);

        // Back-to-back stream: first out_valid three edges after first acceptance, no bubbles.
        a_out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k < 16) begin
                a_in_valid = 1'b1;
                a_in_data  = 8'(k + 1);
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            if (k < 16) check("a_stream_rdy", a_in_ready, 1);
            @(posedge clk);
            #1;
            check("a_stream_vld", a_out_valid, (k >= 2) && (k < 18));
        end

        // Backpressure: exactly six beats fit, then release and finish the stream.
        a_out_ready = 1'b0;
        nxt = 1;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(nxt);
            #1;
            if (a_in_ready) begin
                acc++;
                nxt++;
            end
            @(posedge clk);
            #1;
        end
        check("a_bp_accepted", acc, 6);
        check("a_bp_rdy_low", a_in_ready, 0);
        a_out_ready = 1'b1;
        for (int k = 0; k < 40 && nxt <= 16; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(nxt);
            #1;
            if (a_in_ready) nxt++;
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        check("a_bp_all_sent", nxt, 17);
        repeat (8) @(posedge clk);
        #1;
        check("a_bp_drained", qa.size(), 0);

        // Flush with four beats held and 0xAA offered; the output beat in the flush cycle still goes.
        a_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(8'h20 + k);
            @(posedge clk);
            #1;
        end
        a_in_valid  = 1'b1;
        a_in_data   = 8'hAA;
        a_flush     = 1'b1;
        a_out_ready = 1'b1;
        #1;
        check("a_flush_rdy", a_in_ready, 0);
        @(posedge clk);
        #1;
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        check("a_flush_vld", a_out_valid, 0);
`ifdef SVNET_PIPE_COUNT_EN
        check("a_flush_count", a_count, 0);
`endif
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("a_flush_empty", a_out_valid, 0);
        end
        for (int k = 0; k < 3; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(8'h31 + k);
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("a_flush_resume", qa.size(), 0);

        // Reset mid-stream with five beats held.
        a_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(8'h40 + k);
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        a_rst      = 1'b1;
        #1;
        check("a_rst_rdy", a_in_ready, 0);
        @(posedge clk);
        #1;
        check("a_rst_vld", a_out_valid, 0);
        check("a_rst_dat", a_out_data, 0);
        a_rst = 1'b0;
        #1;
        check("a_rst_rdy_after", a_in_ready, 1);
        a_out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(8'h51 + k);
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("a_rst_resume", qa.size(), 0);

        // Random traffic on the combinational-ready pipe.
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            b_out_ready = 1'($urandom_range(0, 1));
            if (!b_in_valid) begin
                b_in_valid = 1'($urandom_range(0, 1));
                b_in_data  = 8'($urandom);
            end
            @(negedge clk);
            b_acc = b_in_valid && b_in_ready;
            if (b_acc) sent++;
            @(posedge clk);
            #1;
            cyc++;
            if (b_acc) b_in_valid = 1'b0;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        check("b_sent", sent, 1000);
        repeat (4) @(posedge clk);
        #1;
        check("b_drained", qb.size(), 0);

        // Pass-through vectors, crossing a clock edge between rows so rst/flush are sampled.
        for (int i = 0; i < 8; i++) begin
            c_rst       = tv[i].rst;
            c_flush     = tv[i].flush;
            c_in_valid  = tv[i].in_valid;
            c_in_data   = tv[i].in_data;
            c_out_ready = tv[i].out_ready;
            #2;
            check("c_out_valid", c_out_valid, tv[i].exp_valid);
            check("c_out_data", c_out_data, tv[i].exp_data);
            check("c_in_ready", c_in_ready, tv[i].exp_ready);
`ifdef SVNET_PIPE_COUNT_EN
            check("c_count", c_count, 0);
`endif
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
